// File: rtl/ammo_resupply_pkg.sv
// Shared constants, state encoding and helpers for the ammo resupply feeder.
// Imported by the interface, the staging accumulator and the top level.
package ammo_resupply_pkg;

    localparam int N         = 9;
    localparam int RW        = 12;
    localparam int MAG_MAX   = 500;
    localparam int CHUNK     = 50;
    localparam int LOW_WATER = 25;

    // Mode code shared with the weapons block.
    localparam logic [3:0] MODE_ATTACK = 4'b0010;

    localparam logic [N-1:0]  MAG_MAX_N   = N'(MAG_MAX);
    localparam logic [RW-1:0] MAG_MAX_RW  = RW'(MAG_MAX);
    localparam logic [RW-1:0] CHUNK_RW    = RW'(CHUNK);
    localparam logic [N-1:0]  LOW_WATER_N = N'(LOW_WATER);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STAGE  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    function automatic logic [N-1:0] clamp_mag(input logic [N-1:0] lvl);
        return (lvl > MAG_MAX_N) ? MAG_MAX_N : lvl;
    endfunction

endpackage

// File: rtl/ammo_resupply_if.sv
// Magazine-load side bus between the resupply feeder (slave) and its
// environment / ammo counter (master).
interface ammo_resupply_if;
    import ammo_resupply_pkg::*;

    logic [N-1:0]  mag_level;
    logic          reload_req;
    logic          reserve_load;
    logic [RW-1:0] reserve_in;
    logic          load_out;
    logic [N-1:0]  ammo_out;
    logic          fire_inhibit;
    logic          busy;
    logic          empty_err;
    logic [RW-1:0] reserve_level;

    modport master (
        output mag_level, reload_req, reserve_load, reserve_in,
        input  load_out, ammo_out, fire_inhibit, busy, empty_err, reserve_level
    );

    modport slave (
        input  mag_level, reload_req, reserve_load, reserve_in,
        output load_out, ammo_out, fire_inhibit, busy, empty_err, reserve_level
    );

endinterface

// File: rtl/ammo_resupply_stage_accum.sv
// Staging accumulator: chunked step computation plus the staged/reserve
// registers with clear, saturating restock and decrement controls.
module ammo_stage_accum
    import ammo_resupply_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          restock,
    input  logic [RW-1:0] restock_amt,
    input  logic          decrement,
    input  logic [RW-1:0] need,
    output logic [RW-1:0] step,
    output logic [RW-1:0] staged,
    output logic [RW-1:0] reserve,
    output logic [RW-1:0] reserve_restocked,
    output logic          last_step
);

    logic [RW-1:0] staged_r;
    logic [RW-1:0] reserve_r;
    logic [RW-1:0] remain_s;
    logic [RW-1:0] chunk_lim_s;
    logic [RW-1:0] step_s;
    logic [RW:0]   sum_s;
    logic [RW-1:0] restocked_s;
    logic          last_step_s;

    // Step = min(CHUNK, need - staged, reserve) and saturating restock sum.
    always_comb begin
        remain_s    = need - staged_r;
        chunk_lim_s = (remain_s < CHUNK_RW) ? remain_s : CHUNK_RW;
        step_s      = (reserve_r < chunk_lim_s) ? reserve_r : chunk_lim_s;
        last_step_s = ((staged_r + step_s) == need) || (reserve_r == step_s);
        sum_s       = {1'b0, reserve_r} + {1'b0, restock_amt};
        if (sum_s[RW]) begin
            restocked_s = {RW{1'b1}};
        end else begin
            restocked_s = sum_s[RW-1:0];
        end
    end

    // Staged and reserve registers; decrement has priority since it only
    // occurs while staging, when clear/restock are never requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staged_r  <= '0;
            reserve_r <= '0;
        end else if (decrement) begin
            staged_r  <= staged_r + step_s;
            reserve_r <= reserve_r - step_s;
        end else begin
            if (clear) begin
                staged_r <= '0;
            end
            if (restock) begin
                reserve_r <= restocked_s;
            end
        end
    end

    assign step              = step_s;
    assign staged            = staged_r;
    assign reserve           = reserve_r;
    assign reserve_restocked = restocked_s;
    assign last_step         = last_step_s;

endmodule

// File: rtl/ammo_resupply.sv
// Magazine resupply feeder: stages rounds from the reserve, then parallel-loads
// the ammo counter. Optional auto-reload below LOW_WATER: AMMO_RESUPPLY_AUTO_RELOAD_EN.
module ammo_resupply
    import ammo_resupply_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ammo_resupply_if.slave bus
);

    state_e        state_r;
    logic [N-1:0]  snap_r;
    logic [N-1:0]  ammo_out_r;
    logic          load_out_r;
    logic          busy_r;
    logic          empty_err_r;

    logic [RW-1:0] step_s;
    logic [RW-1:0] staged_s;
    logic [RW-1:0] reserve_s;
    logic [RW-1:0] restocked_s;
    logic [RW-1:0] reserve_eff_s;
    logic [RW-1:0] need_idle_s;
    logic [RW-1:0] need_stage_s;
    logic          last_step_s;
    logic          restock_s;
    logic          decrement_s;
    logic          empty_s;
    logic          start_s;
    logic          auto_req_s;
    logic          req_s;

    ammo_stage_accum u_accum (
        .clk               (clk),
        .rst               (rst),
        .clear             (start_s),
        .restock           (restock_s),
        .restock_amt       (bus.reserve_in),
        .decrement         (decrement_s),
        .need              (need_stage_s),
        .step              (step_s),
        .staged            (staged_s),
        .reserve           (reserve_s),
        .reserve_restocked (restocked_s),
        .last_step         (last_step_s)
    );

    assign need_idle_s  = MAG_MAX_RW - RW'(clamp_mag(bus.mag_level));
    assign need_stage_s = MAG_MAX_RW - RW'(snap_r);
    assign decrement_s  = (state_r == ST_STAGE);

    // IDLE decisions; a same-cycle restock is visible to the reserve test.
    always_comb begin
        restock_s     = 1'b0;
        empty_s       = 1'b0;
        start_s       = 1'b0;
        reserve_eff_s = bus.reserve_load ? restocked_s : reserve_s;
`ifdef AMMO_RESUPPLY_AUTO_RELOAD_EN
        auto_req_s    = (bus.mag_level < LOW_WATER_N) && (reserve_eff_s != '0);
`else
        auto_req_s    = 1'b0;
`endif
        req_s         = bus.reload_req | auto_req_s;
        if (state_r == ST_IDLE) begin
            restock_s = bus.reserve_load;
            if (bus.reload_req && (reserve_eff_s == '0)) begin
                empty_s = 1'b1;
            end else if (req_s && (need_idle_s != '0)) begin
                start_s = 1'b1;
            end else begin
                empty_s = 1'b0;
                start_s = 1'b0;
            end
        end else begin
            restock_s = 1'b0;
        end
    end

    // Transfer FSM with registered strobes and busy decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            snap_r      <= '0;
            load_out_r  <= 1'b0;
            ammo_out_r  <= '0;
            busy_r      <= 1'b0;
            empty_err_r <= 1'b0;
        end else begin
            load_out_r  <= 1'b0;
            empty_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    empty_err_r <= empty_s;
                    if (start_s) begin
                        state_r <= ST_STAGE;
                        snap_r  <= clamp_mag(bus.mag_level);
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_STAGE: begin
                    if (last_step_s) begin
                        state_r    <= ST_COMMIT;
                        load_out_r <= 1'b1;
                        ammo_out_r <= N'(RW'(snap_r) + staged_s + step_s);
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_out      = load_out_r;
    assign bus.ammo_out      = ammo_out_r;
    assign bus.fire_inhibit  = busy_r;
    assign bus.busy          = busy_r;
    assign bus.empty_err     = empty_err_r;
    assign bus.reserve_level = reserve_s;

endmodule

// File: tb/tb_ammo_resupply.sv
// Bench for ammo_resupply: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ammo_resupply;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ammo_resupply_if bus ();

    ammo_resupply dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transfer moves min(need, reserve) rounds in
    // ceil(moved/50) staging cycles, then commit and settle.
    int m_reserve, m_start_res, m_moved, m_k, m_snap, m_t;
    bit m_busy;
    int exp_reserve, exp_ammo;
    bit exp_load, exp_busy, exp_empty;

    always @(posedge clk or posedge rst) begin
        int res, lvl, need, sent;
        bit auto_go;
        if (rst) begin
            m_reserve = 0; m_busy = 0; m_t = 0;
            exp_reserve = 0; exp_ammo = 0;
            exp_load = 0; exp_busy = 0; exp_empty = 0;
        end else if (!m_busy) begin
            res = m_reserve;
            if (bus.reserve_load) begin
                res = res + int'(bus.reserve_in);
                if (res > 4095) res = 4095;
            end
            lvl  = (int'(bus.mag_level) > 500) ? 500 : int'(bus.mag_level);
            need = 500 - lvl;
            auto_go = 1'b0;
`ifdef AMMO_RESUPPLY_AUTO_RELOAD_EN
            auto_go = (int'(bus.mag_level) < 25) && (res > 0);
`endif
            exp_load  = 0;
            exp_empty = 0;
            if (bus.reload_req && res == 0) begin
                exp_empty = 1;
            end else if ((bus.reload_req || auto_go) && need > 0) begin
                m_moved = (need < res) ? need : res;
                m_k = (m_moved + 49) / 50;
                if (m_k < 1) m_k = 1;
                m_snap = lvl; m_start_res = res; m_t = 0; m_busy = 1;
            end
            m_reserve   = res;
            exp_reserve = res;
            exp_busy    = m_busy;
        end else begin
            m_t = m_t + 1;
            sent = m_t * 50;
            if (sent > m_moved) sent = m_moved;
            exp_reserve = m_start_res - sent;
            exp_empty   = 0;
            exp_load    = (m_t == m_k);
            if (exp_load) exp_ammo = m_snap + m_moved;
            if (m_t == m_k + 2) begin
                m_busy = 0;
                exp_busy = 0;
                m_reserve = m_start_res - m_moved;
            end
        end
    end

    // Per-cycle comparison against the model, just after each rising edge.
    always @(posedge clk) begin
        #1;
        check("load_out",      32'(bus.load_out),      32'(exp_load));
        check("ammo_out",      32'(bus.ammo_out),      32'(exp_ammo));
        check("fire_inhibit",  32'(bus.fire_inhibit),  32'(exp_busy));
        check("busy",          32'(bus.busy),          32'(exp_busy));
        check("empty_err",     32'(bus.empty_err),     32'(exp_empty));
        check("reserve_level", 32'(bus.reserve_level), 32'(exp_reserve));
    end

    task automatic restock(input int amt);
        @(negedge clk);
        bus.reserve_load = 1'b1;
        bus.reserve_in   = 12'(amt);
        @(negedge clk);
        bus.reserve_load = 1'b0;
        bus.reserve_in   = 12'd0;
    endtask

    task automatic start_req(input int lvl);
        @(negedge clk);
        bus.mag_level  = 9'(lvl);
        bus.reload_req = 1'b1;
    endtask

    task automatic wait_transfer(input bit drop, output int ammo, output int stages, output int inh);
        bit seen, done;
        ammo = -1; stages = -1; inh = 0; seen = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            bus.reload_req = 1'b0;
            if (drop && i == 1) begin
                bus.reserve_load = 1'b1;
                bus.reserve_in   = 12'd77;
            end else begin
                bus.reserve_load = 1'b0;
                bus.reserve_in   = 12'd0;
            end
            if (bus.fire_inhibit) inh++;
            if (bus.load_out) begin
                ammo = int'(bus.ammo_out);
                stages = inh - 1;
                seen = 1;
            end
            if (!bus.busy && inh > 0) done = 1;
        end
        bus.mag_level = 9'd500;
        check("transfer_done", 32'(done), 32'd1);
        check("load_seen",     32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ammo, stages, inh, cnt_a, cnt_b;
        bus.mag_level = 9'd500; bus.reload_req = 1'b0;
        bus.reserve_load = 1'b0; bus.reserve_in = 12'd0;
        #1;
        check("rst_load_out", 32'(bus.load_out), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_reserve",  32'(bus.reserve_level), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Partial reserve: 300 in reserve, magazine at 100.
        restock(300);
        start_req(100);
        wait_transfer(0, ammo, stages, inh);
        check("partial_ammo", 32'(ammo), 32'd400);
        check("partial_stages", 32'(stages), 32'd6);
        check("partial_inhibit", 32'(inh), 32'd8);
        check("partial_reserve", 32'(bus.reserve_level), 32'd0);

        // Small need.
        restock(1000);
        start_req(480);
        wait_transfer(0, ammo, stages, inh);
        check("small_ammo", 32'(ammo), 32'd500);
        check("small_stages", 32'(stages), 32'd1);
        check("small_inhibit", 32'(inh), 32'd3);
        check("small_reserve", 32'(bus.reserve_level), 32'd980);

        // Full (and over-full) magazine: no transfer.
        for (int j = 0; j < 2; j++) begin
            start_req(j == 0 ? 500 : 511);
            cnt_a = 0; cnt_b = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                bus.reload_req = 1'b0;
                if (bus.busy) cnt_a++;
                if (bus.load_out) cnt_b++;
            end
            bus.mag_level = 9'd500;
            check("full_busy", 32'(cnt_a), 32'd0);
            check("full_load", 32'(cnt_b), 32'd0);
            check("full_reserve", 32'(bus.reserve_level), 32'd980);
        end

        // Drain the reserve with two empty-magazine reloads.
        start_req(0);
        wait_transfer(0, ammo, stages, inh);
        check("drain1_ammo", 32'(ammo), 32'd500);
        check("drain1_stages", 32'(stages), 32'd10);
        check("drain1_reserve", 32'(bus.reserve_level), 32'd480);
        start_req(0);
        wait_transfer(0, ammo, stages, inh);
        check("drain2_ammo", 32'(ammo), 32'd480);
        check("drain2_stages", 32'(stages), 32'd10);
        check("drain2_reserve", 32'(bus.reserve_level), 32'd0);

        // Request with empty reserve.
        start_req(100);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.reload_req = 1'b0;
            if (bus.empty_err) cnt_a++;
            if (bus.busy) cnt_b++;
        end
        bus.mag_level = 9'd500;
        check("empty_pulses", 32'(cnt_a), 32'd1);
        check("empty_busy", 32'(cnt_b), 32'd0);

        // Same-cycle restock and request; a restock during STAGE is dropped.
        @(negedge clk);
        bus.reserve_load = 1'b1; bus.reserve_in = 12'd200;
        bus.mag_level = 9'd0; bus.reload_req = 1'b1;
        wait_transfer(1, ammo, stages, inh);
        check("simul_ammo", 32'(ammo), 32'd200);
        check("simul_stages", 32'(stages), 32'd4);
        check("simul_reserve", 32'(bus.reserve_level), 32'd0);

        // Reserve saturation.
        restock(4000);
        restock(500);
        check("sat_reserve", 32'(bus.reserve_level), 32'd4095);

        // Reset mid-STAGE.
        start_req(0);
        repeat (3) begin
            @(negedge clk);
            bus.reload_req = 1'b0;
        end
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_load",    32'(bus.load_out),      32'd0);
        check("mid_rst_ammo",    32'(bus.ammo_out),      32'd0);
        check("mid_rst_inhibit", 32'(bus.fire_inhibit),  32'd0);
        check("mid_rst_busy",    32'(bus.busy),          32'd0);
        check("mid_rst_empty",   32'(bus.empty_err),     32'd0);
        check("mid_rst_reserve", 32'(bus.reserve_level), 32'd0);
        bus.mag_level = 9'd500;
        @(negedge clk);
        rst = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.load_out) cnt_a++;
        end
        check("post_rst_load", 32'(cnt_a), 32'd0);
        check("post_rst_reserve", 32'(bus.reserve_level), 32'd0);

`ifdef AMMO_RESUPPLY_AUTO_RELOAD_EN
        // Auto reload below the low-water mark.
        restock(100);
        @(negedge clk);
        bus.mag_level = 9'd20;
        wait_transfer(0, ammo, stages, inh);
        check("auto_ammo", 32'(ammo), 32'd120);
        check("auto_stages", 32'(stages), 32'd2);
        check("auto_reserve", 32'(bus.reserve_level), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
